player_motion_ctrl: RTL

//  Produces the top-left sprite position (player_x/player_y) that drives player_renderer for one player token.

---
 rtl/game_pkg.sv | 29 ++
 rtl/board_tile_lut.sv | 22 ++
 rtl/player_motion_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared board geometry and motion types for the player token.
// No ports: types, geometry constants and a tile-advance helper.
package game_pkg;

    typedef logic [4:0] tile_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        HOP,
        SETTLE
    } motion_state_e;

    localparam int NUM_TILES  = 32;
    localparam int BOARD_COLS = 8;
    localparam int BOARD_X0   = 64;
    localparam int BOARD_Y0   = 48;
    localparam int TILE_W     = 64;
    localparam int TILE_H     = 64;
    localparam int SPRITE_W   = 16;
    localparam int SPRITE_H   = 16;
    localparam int POS_W      = 10;

    function automatic tile_idx_t next_tile(input tile_idx_t i);
        if (int'(i) == NUM_TILES - 1)
            return '0;
        return tile_idx_t'(i + 1'b1);
    endfunction

endpackage

// File: rtl/board_tile_lut.sv
// Combinational tile index -> sprite top-left pixel on the serpentine board.
// Ports: idx (tile index) in; x, y (sprite top-left) out.
module board_tile_lut
    import game_pkg::*;
(
    input  tile_idx_t        idx,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y
);

    logic [1:0] row;
    logic [2:0] col;

    always_comb begin
        row = idx[4:3];
        // Odd rows run right-to-left; ~i%8 == 7-i%8 for a 3-bit column.
        col = row[0] ? ~idx[2:0] : idx[2:0];
        x = POS_W'(BOARD_X0 + int'(col) * TILE_W + (TILE_W - SPRITE_W) / 2);
        y = POS_W'(BOARD_Y0 + int'(row) * TILE_H + TILE_H - SPRITE_H);
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Walks one player token tile-by-tile with per-frame interpolated hops.
// Ports: clk, reset, frame_tick, move/warp requests in; move_ready, busy,
//        move_done, lap_pulse, tile_idx, player_x, player_y out (registered).
module player_motion_ctrl
    import game_pkg::*;
#(
    parameter int STEP_FRAMES   = 16,
    parameter int HOP_HEIGHT    = 8,
    parameter int SETTLE_FRAMES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             move_valid,
    input  logic [2:0]       move_steps,
    input  logic             warp_valid,
    input  logic [4:0]       warp_idx,
    output logic             move_ready,
    output logic             busy,
    output logic             move_done,
    output logic             lap_pulse,
    output tile_idx_t        tile_idx,
    output logic [POS_W-1:0] player_x,
    output logic [POS_W-1:0] player_y
);

    localparam int FW = $clog2(STEP_FRAMES);
    localparam int GW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    // Wide enough for a full-row vertical delta (-192) times f.
    localparam int IW = 14;
    localparam logic signed [IW-1:0] S_DIV = IW'(STEP_FRAMES);

    motion_state_e    state, state_n;
    logic [FW-1:0]    f, f_n, f_inc;
    logic [GW-1:0]    g, g_n;
    logic [2:0]       steps_left, steps_n;
    tile_idx_t        nxt, nxt_n, tile_n;
    logic             warp_pend, pend_n;
    logic [POS_W-1:0] x_n, y_n;
    logic             done_n, lap_n, ready_n, busy_n;

    logic [POS_W-1:0] cur_x, cur_y, nxt_x, nxt_y;
    logic signed [IW-1:0] dx, dy, qx, qy;
    logic [IW-1:0]        hop;
    logic [POS_W-1:0]     hop_x, hop_y;

    board_tile_lut u_cur (
        .idx (tile_idx),
        .x   (cur_x),
        .y   (cur_y)
    );

    // Also resolves the warp destination while a warp is pending.
    board_tile_lut u_nxt (
        .idx (nxt),
        .x   (nxt_x),
        .y   (nxt_y)
    );

    always_comb begin
        f_inc = f + 1'b1;
        dx = $signed(IW'(nxt_x)) - $signed(IW'(cur_x));
        dy = $signed(IW'(nxt_y)) - $signed(IW'(cur_y));
        // Signed divide truncates toward zero.
        qx = (dx * $signed(IW'(f_inc))) / S_DIV;
        qy = (dy * $signed(IW'(f_inc))) / S_DIV;
        hop = (IW'(4 * HOP_HEIGHT) * IW'(f_inc)
              * (IW'(STEP_FRAMES) - IW'(f_inc))) >> (2 * FW);
        hop_x = POS_W'($signed(IW'(cur_x)) + qx);
        hop_y = POS_W'($signed(IW'(cur_y)) + qy - $signed(hop));
    end

    always_comb begin
        state_n = state;
        f_n     = f;
        g_n     = g;
        steps_n = steps_left;
        nxt_n   = nxt;
        pend_n  = warp_pend;
        tile_n  = tile_idx;
        x_n     = player_x;
        y_n     = player_y;
        done_n  = 1'b0;
        lap_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (warp_pend) begin
                    if (frame_tick) begin
                        tile_n = nxt;
                        x_n    = nxt_x;
                        y_n    = nxt_y;
                        done_n = 1'b1;
                        pend_n = 1'b0;
                    end
                end else if (move_valid && move_ready) begin
                    if (move_steps == 3'd0) begin
                        done_n = 1'b1;
                    end else begin
                        steps_n = move_steps;
                        nxt_n   = next_tile(tile_idx);
                        f_n     = '0;
                        state_n = HOP;
                    end
                end else if (warp_valid && move_ready) begin
                    pend_n = 1'b1;
                    nxt_n  = warp_idx;
                end
            end
            HOP: begin
                if (frame_tick) begin
                    if (f == FW'(STEP_FRAMES - 1)) begin
                        tile_n  = nxt;
                        x_n     = nxt_x;
                        y_n     = nxt_y;
                        steps_n = steps_left - 3'd1;
                        lap_n   = (nxt == '0);
                        g_n     = '0;
                        state_n = SETTLE;
                    end else begin
                        f_n = f_inc;
                        x_n = hop_x;
                        y_n = hop_y;
                    end
                end
            end
            SETTLE: begin
                if (frame_tick) begin
                    if (g == GW'(SETTLE_FRAMES - 1)) begin
                        if (steps_left == 3'd0) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            nxt_n   = next_tile(tile_idx);
                            f_n     = '0;
                            state_n = HOP;
                        end
                    end else begin
                        g_n = g + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // A pending warp holds off new requests until it lands.
        ready_n = (state_n == IDLE) && !pend_n;
        busy_n  = !ready_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            f          <= '0;
            g          <= '0;
            steps_left <= '0;
            nxt        <= '0;
            warp_pend  <= 1'b0;
            tile_idx   <= '0;
            player_x   <= POS_W'(BOARD_X0 + (TILE_W - SPRITE_W) / 2);
            player_y   <= POS_W'(BOARD_Y0 + TILE_H - SPRITE_H);
            move_ready <= 1'b1;
            busy       <= 1'b0;
            move_done  <= 1'b0;
            lap_pulse  <= 1'b0;
        end else begin
            state      <= state_n;
            f          <= f_n;
            g          <= g_n;
            steps_left <= steps_n;
            nxt        <= nxt_n;
            warp_pend  <= pend_n;
            tile_idx   <= tile_n;
            player_x   <= x_n;
            player_y   <= y_n;
            move_ready <= ready_n;
            busy       <= busy_n;
            move_done  <= done_n;
            lap_pulse  <= lap_n;
        end
    end

endmodule
